// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared state type and clock constants for freq_meter
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    DONE
  } state_t;

  localparam int CLK_HZ  = 50_000_000;
  localparam int GATE_1S = CLK_HZ;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchronizer with rising-edge pulse for async inputs
module sync_edge_detect (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic async_in,
  output logic level_out,
  output logic rise_pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign level_out  = sync2;
  assign rise_pulse = sync2 & ~prev;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - counts sig_in rising edges per gate window and CLOCK_50 cycles between edges
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_1S,
  parameter int CNT_W       = 27,
  parameter int PER_W       = 32
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic [PER_W-1:0] period_out,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [PER_W-1:0]  PER_MAX   = '1;

  state_t             state;
  state_t             state_next;
  logic [GATE_W-1:0]  gate_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               sat;
  logic               sat_next;
  logic [PER_W-1:0]   per_cnt;
  logic               have_edge;
  logic               sig_level;
  logic               sig_rise;
  logic               rise;
  logic               gate_clear;
  logic               gate_last;

  sync_edge_detect u_sync (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .async_in   (sig_in),
    .level_out  (sig_level),
    .rise_pulse (sig_rise)
  );

  // The pulse already implies the synchronized level is high; qualifying keeps both taps in use.
  assign rise = sig_rise & sig_level;

  assign gate_clear = (state != GATE) && enable;
  assign gate_last  = (state == GATE) && enable && (gate_cnt == GATE_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    valid      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = GATE;
      end
      GATE: begin
        busy = 1'b1;
        if (!enable)                     state_next = IDLE;
        else if (gate_cnt == GATE_LAST)  state_next = DONE;
      end
      DONE: begin
        valid      = 1'b1;
        state_next = enable ? GATE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Edge count for this cycle, so an edge in the final gate cycle still lands in freq_out.
  always_comb begin
    cnt_next = edge_cnt;
    sat_next = sat;
    if (rise) begin
      if (edge_cnt == CNT_MAX) sat_next = 1'b1;
      else                     cnt_next = edge_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
      freq_out <= '0;
      overflow <= 1'b0;
    end else begin
      if (gate_clear) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        sat      <= 1'b0;
      end else if (state == GATE) begin
        gate_cnt <= gate_cnt + GATE_W'(1);
        edge_cnt <= cnt_next;
        sat      <= sat_next;
      end
      if (gate_last) begin
        freq_out <= cnt_next;
        overflow <= sat_next;
      end
    end
  end

  // Period path free-runs on enable; the first edge only arms it.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      per_cnt    <= '0;
      have_edge  <= 1'b0;
      period_out <= '0;
    end else if (!enable) begin
      per_cnt   <= '0;
      have_edge <= 1'b0;
    end else if (rise) begin
      if (have_edge) period_out <= per_cnt;
      per_cnt   <= PER_W'(1);
      have_edge <= 1'b1;
    end else if (per_cnt != PER_MAX) begin
      per_cnt <= per_cnt + PER_W'(1);
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - randomized self-checking bench for freq_meter against a window/edge-time model
module tb_freq_meter;

  localparam int     G      = 100;
  localparam int     CW_A   = 27;
  localparam int     PW_A   = 32;
  localparam int     CW_B   = 3;
  localparam int     PW_B   = 4;
  localparam int     MAXC   = 8192;
  localparam longint CMAX_A = (64'd1 << CW_A) - 1;
  localparam longint PMAX_A = (64'd1 << PW_A) - 1;
  localparam longint CMAX_B = (64'd1 << CW_B) - 1;
  localparam longint PMAX_B = (64'd1 << PW_B) - 1;

  logic            clk    = 1'b0;
  logic            reset  = 1'b1;
  logic            enable = 1'b0;
  logic            sig_in = 1'b0;

  logic [CW_A-1:0] freq_a;
  logic [PW_A-1:0] period_a;
  logic            valid_a, overflow_a, busy_a;
  logic [CW_B-1:0] freq_b;
  logic [PW_B-1:0] period_b;
  logic            valid_b, overflow_b, busy_b;

  always #5 clk = ~clk;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(CW_A), .PER_W(PW_A)) dut_a (
    .CLOCK_50(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .freq_out(freq_a), .period_out(period_a), .valid(valid_a),
    .overflow(overflow_a), .busy(busy_a)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(CW_B), .PER_W(PW_B)) dut_b (
    .CLOCK_50(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .freq_out(freq_b), .period_out(period_b), .valid(valid_b),
    .overflow(overflow_b), .busy(busy_b)
  );

  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  int     half   = 0;
  int     hc     = 0;
  bit     s_h [MAXC];
  bit     r_h [MAXC];

  // Reference: a window opens on an enabled cycle not already inside one and covers the next G cycles.
  bit     win_open  = 1'b0;
  int     win_start = 0;
  longint cnt       = 0;
  longint res_cnt   = 0;
  longint last_edge = -1;
  longint per_gap   = 0;
  bit     exp_valid = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat_to(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // sig_in rising between the samples at m-3 and m-2 is seen by the counters at edge m.
  function automatic bit edge_at(input int m);
    bit lvl, prv;
    if (m < 3) return 1'b0;
    lvl = (!r_h[m-1] && !r_h[m-2]) ? s_h[m-2] : 1'b0;
    prv = (!r_h[m-1] && !r_h[m-2] && !r_h[m-3]) ? s_h[m-3] : 1'b0;
    return lvl & ~prv;
  endfunction

  task automatic tick();
    bit e;
    int n;
    @(posedge clk);
    n = cyc;
    if (n >= MAXC) begin
      $display("FAIL cycle_budget observed=%0d expected<%0d", n, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    s_h[n] = sig_in;
    r_h[n] = reset;
    e = edge_at(n);
    exp_valid = 1'b0;
    if (reset) begin
      win_open  = 1'b0;
      res_cnt   = 0;
      last_edge = -1;
      per_gap   = 0;
    end else begin
      if (win_open) begin
        if (!enable) win_open = 1'b0;
        else begin
          cnt += longint'(e);
          if (n == win_start + G) begin
            win_open  = 1'b0;
            res_cnt   = cnt;
            exp_valid = 1'b1;
          end
        end
      end else if (enable) begin
        win_open  = 1'b1;
        win_start = n;
        cnt       = 0;
      end
      if (!enable) last_edge = -1;
      else if (e) begin
        if (last_edge >= 0) per_gap = longint'(n) - last_edge;
        last_edge = n;
      end
    end
    cyc++;
    @(negedge clk);
    check("freq_a",   freq_a,     sat_to(res_cnt, CMAX_A));
    check("ovf_a",    overflow_a, res_cnt > CMAX_A);
    check("period_a", period_a,   sat_to(per_gap, PMAX_A));
    check("valid_a",  valid_a,    exp_valid);
    check("busy_a",   busy_a,     win_open);
    check("freq_b",   freq_b,     sat_to(res_cnt, CMAX_B));
    check("ovf_b",    overflow_b, res_cnt > CMAX_B);
    check("period_b", period_b,   sat_to(per_gap, PMAX_B));
    check("valid_b",  valid_b,    exp_valid);
    check("busy_b",   busy_b,     win_open);
    if (half > 0) begin
      hc++;
      if (hc >= half) begin
        sig_in = ~sig_in;
        hc     = 0;
      end
    end
  endtask

  task automatic wait_valid();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * G && !found; i++) begin
      tick();
      if (valid_a === 1'b1) found = 1'b1;
    end
    check("valid_wait", found, 1'b1);
  endtask

  initial begin
    int t_en;
    int t0;
    int seg_len;

    half = 5;
    repeat (20) tick();
    check("rst_freq", freq_a, 0);
    check("rst_busy", busy_a, 0);
    reset = 1'b0;
    repeat (10) tick();
    check("idle_period", period_a, 0);
    check("idle_valid",  valid_a,  0);

    t_en   = cyc;
    enable = 1'b1;
    tick();
    check("busy_rise", busy_a, 1);
    wait_valid();
    check("first_valid_lat", cyc - 1 - t_en, G);
    check("p10_freq",   freq_a,     10);
    check("p10_ovf",    overflow_a, 0);
    check("p10_period", period_a,   10);

    for (int w = 0; w < 2; w++) begin
      t0 = cyc;
      wait_valid();
      check("valid_spacing", cyc - t0, G + 1);
      check("p10_freq_rep",  freq_a,   10);
    end

    half = 4;
    wait_valid();
    wait_valid();
    check("p8_freq_range", (freq_a == 12 || freq_a == 13), 1);
    check("p8_period",     period_a, 8);

    half = 2;
    wait_valid();
    wait_valid();
    check("p4_freq_a",  freq_a,     25);
    check("p4_freq_b",  freq_b,     7);
    check("p4_ovf_b",   overflow_b, 1);
    check("p4_period_b", period_b,  4);

    half = 10;
    wait_valid();
    wait_valid();
    check("p20_freq_b",   freq_b,     5);
    check("p20_ovf_b",    overflow_b, 0);
    check("p20_period_a", period_a,   20);
    check("p20_period_b", period_b,   15);

    repeat (50) tick();
    enable = 1'b0;
    tick();
    check("abort_busy",  busy_a,  0);
    check("abort_valid", valid_a, 0);
    check("abort_hold",  freq_a,  20'd5);
    repeat (G + 10) tick();

    enable = 1'b1;
    repeat (30) tick();
    reset = 1'b1;
    tick();
    check("midrst_freq",   freq_a,   0);
    check("midrst_period", period_a, 0);
    check("midrst_busy",   busy_a,   0);
    reset = 1'b0;

    for (int s = 0; s < 8; s++) begin
      half    = int'($urandom_range(1, 14));
      enable  = ($urandom_range(0, 3) != 0);
      seg_len = int'($urandom_range(20, 260));
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      repeat (seg_len) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures an incoming slow square wave, such as a divided board clock, against CLOCK_50.
- Outputs rising edges counted per fixed gate window (frequency) and CLOCK_50 cycles between consecutive rising edges (period).
- Sits next to the clock dividers to check their output rate, in simulation and on the board (7-seg/LED readout).

Parameters:
- GATE_CYCLES, 50_000_000, gate window length in CLOCK_50 cycles (1 s at 50 MHz); minimum 2.
- CNT_W, 27, width of the edge counter and freq_out.
- PER_W, 32, width of the period counter and period_out.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = run measurements continuously, 0 = stop.
- sig_in  in  1  signal under test; asynchronous to CLOCK_50.
- freq_out  out  CNT_W  rising edges counted in the last completed gate.
- period_out  out  PER_W  CLOCK_50 cycles between the last two rising edges.
- valid  out  1  one-cycle pulse when freq_out is updated.
- overflow  out  1  edge count saturated in the last completed gate.
- busy  out  1  1 while a gate window is open.

Behaviour:
- Reset:
  - Synchronous, active-high, on the CLOCK_50 rising edge; the only clock is CLOCK_50.
  - freq_out, period_out, valid, overflow and busy are 0; state is IDLE.
  - All internal counters and synchronizer flops are 0.
  - Reset asserted mid-gate aborts the gate with no valid pulse.
- Input conditioning:
  - sig_in passes through a 2-flop synchronizer, then a delay flop.
  - edge = sync2 & ~prev.
  - A sig_in rise registers as edge 3 cycles later.
  - edge is a single-cycle pulse.
- State machine, one-hot or encoded: IDLE, GATE, DONE.
  - IDLE: busy=0. If enable=1: gate_cnt<=0, edge_cnt<=0, go to GATE.
  - GATE: busy=1, gate_cnt increments each cycle, edge_cnt increments on edge.
    - If enable=0: go to IDLE; outputs hold previous values; no valid.
    - If gate_cnt==GATE_CYCLES-1: go to DONE. On that edge freq_out <= final count, including an edge in this last cycle. overflow <= sat flag.
  - DONE: valid=1 for exactly this cycle; busy=0.
    - enable=1: clear counters and go to GATE (back-to-back). Edges in the DONE cycle are not counted.
    - enable=0: go to IDLE.
- Timing: enable sampled high in IDLE at cycle t gives GATE in t+1..t+GATE_CYCLES, and valid in t+GATE_CYCLES+1. With enable held, valid repeats every GATE_CYCLES+1 cycles.
- Saturation: edge_cnt holds at 2^CNT_W-1 and sets a sat flag. The flag clears when a new gate starts.
- Period path:
  - Runs whenever enable=1, independent of the gate FSM.
  - per_cnt increments each cycle, saturating at 2^PER_W-1.
  - On edge: if have_edge=1, period_out <= per_cnt; then per_cnt <= 1 and have_edge <= 1.
  - The first edge after enable rises, or after reset, only arms the path and does not update period_out.
  - enable=0 clears have_edge and per_cnt; period_out holds.
- Simultaneous events:
  - An edge in the last GATE cycle is counted.
  - enable falling in the last GATE cycle: go to IDLE, no valid.
  - reset has priority over everything.

Decomposition:
- Package freq_meter_pkg:
  - state enum (IDLE, GATE, DONE).
  - constant CLK_HZ=50_000_000.
  - default gate constant GATE_1S = CLK_HZ.
- Sub-module sync_edge_detect:
  - Ports CLOCK_50, reset, async_in, level_out, rise_pulse.
  - Contains the 2-flop synchronizer plus edge register.
  - Reusable for pushbuttons and other async inputs.

Test Plan (benches use GATE_CYCLES=100 unless stated):
1. reset held 20 cycles with sig_in toggling every 5 cycles -> all outputs 0, busy=0. Release with enable=0 -> outputs stay 0.
2. sig_in period 10 (toggle every 5), enable rises at cycle t -> busy=1 from t+1, valid single pulse at t+101. freq_out=10, overflow=0, period_out=10.
3. Hold enable 3 windows -> valid at t+101, t+202, t+303, freq_out=10 each time. Period 8 input -> freq_out 12 or 13 depending on phase, period_out=8.
4. CNT_W=3, sig_in period 4 -> freq_out=7, overflow=1 with valid. Switch to period 20 -> next window freq_out=5, overflow=0.
5. Deassert enable at gate cycle 50 -> no valid, busy=0 next cycle, freq_out keeps prior value. Assert reset at gate cycle 30 -> all outputs 0 next cycle.
6. PER_W=4, sig_in period 20 -> period_out=15 (saturated). First edge after enable leaves period_out unchanged; second edge updates it.
